// File: rtl/csr_trap_unit_pkg.sv
// csr_trap_unit_pkg: CSR addresses, mstatus/mie bit positions, trap cause codes and CSR op helper
package csr_trap_unit_pkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [31:0] CAUSE_INST_MISALIGN  = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
    localparam logic [31:0] CAUSE_BREAK          = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] CAUSE_ECALL          = 32'd11;
    localparam logic [31:0] CAUSE_MTI            = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI            = 32'h8000_000B;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old, input logic [31:0] opnd);
        return op == CSR_WRITE ? opnd : op == CSR_SET ? (old | opnd) : (old & ~opnd);
    endfunction
endpackage

// File: rtl/csr_trap_unit_counter64.sv
// csr_counter64: 64-bit wrapping counter; a write to either half replaces it and skips that cycle's increment
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);
    logic [63:0] count_d, count_q;

    always_comb begin
        count_d = wr_lo ? {count_q[63:32], wdata} :
                  wr_hi ? {wdata, count_q[31:0]} :
                  count_q + {63'd0, inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer for the multicycle control unit
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_read,
    input  logic        illegal_inst,
    input  logic        inst_addr_misalign,
    input  logic        load_addr_misalign,
    input  logic        store_addr_misalign,
    input  logic        env_call,
    input  logic        env_break,
    input  logic        trap_start,
    input  logic        trap_finish,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] inst_addr,
    input  logic [31:0] data_addr,
    input  logic        csr_write,
    input  logic [31:0] csr_wdata,
    input  logic        instret,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic        trap_pending,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic [31:0] csr_rdata
);
    logic        mstatus_mie_d, mstatus_mie_q, mstatus_mpie_d, mstatus_mpie_q;
    logic        mie_meie_d, mie_meie_q, mie_mtie_d, mie_mtie_q;
    logic [31:0] mtvec_d, mtvec_q, mscratch_d, mscratch_q, mepc_d, mepc_q;
    logic [31:0] mcause_d, mcause_q, mtval_d, mtval_q;
    logic [31:0] cause_d, cause_q, epc_d, epc_q, tval_d, tval_q;
    logic [11:0] csr_addr;
    csr_op_e     csr_op;
    logic        csr_we, exc, irq_take;
    logic [31:0] csr_wval, exc_cause, exc_tval, mip;
    logic [63:0] mcycle, minstret;

    assign csr_addr = inst[31:20];
    assign csr_op   = csr_op_e'(inst[13:12]);
    assign csr_we   = csr_write && csr_op != CSR_NONE;
    assign csr_wval = csr_apply(csr_op, csr_rdata, csr_wdata);
    assign mip      = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
    assign mepc_out = mepc_q;
    assign trap_vector = (mtvec_q[1:0] == 2'b01 && cause_q[31]) ?
                         {mtvec_q[31:2], 2'b00} + (cause_q << 2) : {mtvec_q[31:2], 2'b00};

    // Exceptions (EXECUTE) and interrupts (FETCH) are mutually exclusive; trap_start masks both
    always_comb begin
        exc = inst_addr_misalign | illegal_inst | env_break | load_addr_misalign | store_addr_misalign | env_call;
        exc_cause = inst_addr_misalign ? CAUSE_INST_MISALIGN :
                    illegal_inst ? CAUSE_ILLEGAL :
                    env_break ? CAUSE_BREAK :
                    load_addr_misalign ? CAUSE_LOAD_MISALIGN :
                    store_addr_misalign ? CAUSE_STORE_MISALIGN : CAUSE_ECALL;
        exc_tval = inst_addr_misalign ? inst_addr :
                   illegal_inst ? inst :
                   env_break ? 32'd0 :
                   (load_addr_misalign | store_addr_misalign) ? data_addr : 32'd0;
        irq_take = inst_read && !exc && mstatus_mie_q && ((mie_meie_q && ext_irq) || (mie_mtie_q && timer_irq));
        trap_pending = (exc || irq_take) && !trap_start;
        trap_cause = exc ? exc_cause : (mie_meie_q && ext_irq) ? CAUSE_MEI : CAUSE_MTI;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            CSR_MIE:       csr_rdata = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = mip;
            CSR_MCYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH: csr_rdata = minstret[63:32];
            CSR_MHARTID:   csr_rdata = HART_ID;
            default:       csr_rdata = '0;
        endcase
    end

    // CSR writes first, then trap commit / MRET override them; trap_start wins over trap_finish
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        cause_d        = trap_pending ? trap_cause : cause_q;
        epc_d          = trap_pending ? pc : epc_q;
        tval_d         = trap_pending ? (exc ? exc_tval : 32'd0) : tval_q;
        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wval[MSTATUS_MIE];
                    mstatus_mpie_d = csr_wval[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    mie_meie_d = csr_wval[MIE_MEIE];
                    mie_mtie_d = csr_wval[MIE_MTIE];
                end
                CSR_MTVEC:    mtvec_d    = {csr_wval[31:2], 1'b0, csr_wval[0]};
                CSR_MSCRATCH: mscratch_d = csr_wval;
                CSR_MEPC:     mepc_d     = {csr_wval[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = csr_wval;
                CSR_MTVAL:    mtval_d    = csr_wval;
                default: ;
            endcase
        end
        if (trap_start) begin
            mepc_d         = epc_q;
            mcause_d       = cause_q;
            mtval_d        = tval_q;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (trap_finish) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            cause_q        <= '0;
            epc_q          <= '0;
            tval_q         <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            cause_q        <= cause_d;
            epc_q          <= epc_d;
            tval_q         <= tval_d;
        end
    end

    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .wr_lo (csr_we && csr_addr == CSR_MCYCLE),
        .wr_hi (csr_we && csr_addr == CSR_MCYCLEH),
        .wdata (csr_wval),
        .count (mcycle)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (instret),
        .wr_lo (csr_we && csr_addr == CSR_MINSTRET),
        .wr_hi (csr_we && csr_addr == CSR_MINSTRETH),
        .wdata (csr_wval),
        .count (minstret)
    );
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: table-driven CSR vectors plus hand-written trap/interrupt/counter sequences
module tb_csr_trap_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        inst_read = 0, illegal_inst = 0, inst_addr_misalign = 0, load_addr_misalign = 0;
    logic        store_addr_misalign = 0, env_call = 0, env_break = 0, trap_start = 0, trap_finish = 0;
    logic [31:0] pc = 0, inst = 0, inst_addr = 0, data_addr = 0, csr_wdata = 0;
    logic        csr_write = 0, instret = 0, ext_irq = 0, timer_irq = 0;
    logic        trap_pending;
    logic [31:0] trap_cause, trap_vector, mepc_out, csr_rdata;

    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs [18];
    sb_t  sb_q [$];

    csr_trap_unit dut (
        .clk(clk), .rst_n(rst_n), .inst_read(inst_read), .illegal_inst(illegal_inst),
        .inst_addr_misalign(inst_addr_misalign), .load_addr_misalign(load_addr_misalign),
        .store_addr_misalign(store_addr_misalign), .env_call(env_call), .env_break(env_break),
        .trap_start(trap_start), .trap_finish(trap_finish), .pc(pc), .inst(inst),
        .inst_addr(inst_addr), .data_addr(data_addr), .csr_write(csr_write), .csr_wdata(csr_wdata),
        .instret(instret), .ext_irq(ext_irq), .timer_irq(timer_irq), .trap_pending(trap_pending),
        .trap_cause(trap_cause), .trap_vector(trap_vector), .mepc_out(mepc_out), .csr_rdata(csr_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] v);
        inst = {a, 5'd0, 3'b010, 5'd0, 7'h73};
        csr_write = 1'b0;
        @(negedge clk);
        v = csr_rdata;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        inst = {a, 5'd0, 1'b0, op, 5'd0, 7'h73};
        csr_wdata = d;
        csr_write = 1'b1;
        step();
        csr_write = 1'b0;
    endtask

    task automatic expect_csr(input string name, input logic [11:0] a, input logic [31:0] e);
        sb_t s;
        s.name = name;
        s.addr = a;
        s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic drain;
        sb_t s;
        logic [31:0] v;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            csr_rd(s.addr, v);
            chk(s.name, v, s.exp);
        end
    endtask

    task automatic clear_strobes;
        illegal_inst = 0; inst_addr_misalign = 0; load_addr_misalign = 0;
        store_addr_misalign = 0; env_call = 0; env_break = 0;
    endtask

    // Latch the pending trap at the next edge, then spend one TRAP cycle committing it
    task automatic commit;
        step();
        clear_strobes();
        trap_start = 1;
        step();
        trap_start = 0;
    endtask

    initial begin
        logic [31:0] v0, v1;
        vecs[0]  = '{2'b01, 12'h340, 32'h0,        32'h0,        "mscratch_zero"};
        vecs[1]  = '{2'b10, 12'h340, 32'hF0,       32'hF0,       "mscratch_set"};
        vecs[2]  = '{2'b11, 12'h340, 32'h30,       32'hC0,       "mscratch_clear"};
        vecs[3]  = '{2'b10, 12'h340, 32'h0,        32'hC0,       "mscratch_set0"};
        vecs[4]  = '{2'b01, 12'hF14, 32'hDEAD,     32'h0,        "mhartid_ro"};
        vecs[5]  = '{2'b01, 12'h341, 32'h103,      32'h100,      "mepc_align"};
        vecs[6]  = '{2'b01, 12'h305, 32'h203,      32'h201,      "mtvec_bit1"};
        vecs[7]  = '{2'b01, 12'h300, 32'hFFFFFFFF, 32'h88,       "mstatus_mask"};
        vecs[8]  = '{2'b11, 12'h300, 32'h8,        32'h80,       "mstatus_clr_mie"};
        vecs[9]  = '{2'b01, 12'h300, 32'h0,        32'h0,        "mstatus_zero"};
        vecs[10] = '{2'b01, 12'h304, 32'hFFFFFFFF, 32'h880,      "mie_mask"};
        vecs[11] = '{2'b11, 12'h304, 32'h800,      32'h80,       "mie_clr_meie"};
        vecs[12] = '{2'b01, 12'h342, 32'h8000000B, 32'h8000000B, "mcause_wr"};
        vecs[13] = '{2'b01, 12'h343, 32'h55,       32'h55,       "mtval_wr"};
        vecs[14] = '{2'b01, 12'h344, 32'hFFFFFFFF, 32'h0,        "mip_ro"};
        vecs[15] = '{2'b01, 12'h7C0, 32'h1234,     32'h0,        "unimpl_csr"};
        vecs[16] = '{2'b01, 12'hB02, 32'h5,        32'h5,        "minstret_wr"};
        vecs[17] = '{2'b01, 12'hB82, 32'h7,        32'h7,        "minstreth_wr"};

        repeat (2) step();
        chk("rst_pending", {31'd0, trap_pending}, 32'd0);
        chk("rst_vector", trap_vector, 32'h100);
        rst_n = 1;
        step();
        expect_csr("rst_mtvec", 12'h305, 32'h100);
        expect_csr("rst_mstatus", 12'h300, 32'h0);
        expect_csr("rst_mepc", 12'h341, 32'h0);
        expect_csr("rst_mhartid", 12'hF14, 32'h0);
        drain();
        csr_rd(12'hB00, v0);
        csr_rd(12'hB00, v1);
        chk("mcycle_inc", v1 - v0, 32'd1);

        // ECALL with MIE set; strobe held into TRAP cycle must not re-raise trap_pending
        csr_wr(2'b01, 12'h300, 32'h8);
        pc = 32'h40; env_call = 1;
        @(negedge clk);
        chk("ecall_pending", {31'd0, trap_pending}, 32'd1);
        chk("ecall_cause", trap_cause, 32'd11);
        step();
        trap_start = 1;
        @(negedge clk);
        chk("pending_in_trap", {31'd0, trap_pending}, 32'd0);
        step();
        trap_start = 0; env_call = 0;
        chk("ecall_mepc", mepc_out, 32'h40);
        chk("ecall_vector", trap_vector, 32'h100);
        expect_csr("ecall_mcause", 12'h342, 32'd11);
        expect_csr("ecall_mstatus", 12'h300, 32'h80);
        drain();
        trap_finish = 1;
        step();
        trap_finish = 0;
        expect_csr("ecall_mret", 12'h300, 32'h88);
        drain();
        csr_wr(2'b01, 12'h300, 32'h0);

        pc = 32'h80; inst = 32'hFFFFFFFF; illegal_inst = 1; env_call = 1; load_addr_misalign = 1; data_addr = 32'h1003;
        @(negedge clk);
        chk("illegal_prio", trap_cause, 32'd2);
        commit();
        chk("illegal_mepc", mepc_out, 32'h80);
        expect_csr("illegal_mcause", 12'h342, 32'd2);
        expect_csr("illegal_mtval", 12'h343, 32'hFFFFFFFF);
        drain();

        pc = 32'hA0; inst_addr = 32'h2002; inst_addr_misalign = 1; illegal_inst = 1;
        @(negedge clk);
        chk("iam_prio", trap_cause, 32'd0);
        commit();
        expect_csr("iam_mtval", 12'h343, 32'h2002);
        expect_csr("iam_mcause", 12'h342, 32'd0);
        drain();

        env_break = 1; load_addr_misalign = 1;
        @(negedge clk);
        chk("ebreak_prio", trap_cause, 32'd3);
        env_break = 0; store_addr_misalign = 1; env_call = 1;
        @(negedge clk);
        chk("load_prio", trap_cause, 32'd4);
        load_addr_misalign = 0;
        @(negedge clk);
        chk("store_prio", trap_cause, 32'd6);
        pc = 32'h90; data_addr = 32'h3006;
        commit();
        expect_csr("store_mtval", 12'h343, 32'h3006);
        expect_csr("store_mepc", 12'h341, 32'h90);
        drain();

        foreach (vecs[i]) begin
            csr_wr(vecs[i].op, vecs[i].addr, vecs[i].wdata);
            expect_csr(vecs[i].name, vecs[i].addr, vecs[i].exp);
            drain();
        end

        // Vectored timer interrupt; external is masked in mie so MTI must be chosen
        csr_wr(2'b01, 12'h300, 32'h8);
        timer_irq = 1; ext_irq = 1; pc = 32'h10;
        @(negedge clk);
        chk("irq_no_fetch", {31'd0, trap_pending}, 32'd0);
        inst_read = 1;
        @(negedge clk);
        chk("irq_pending", {31'd0, trap_pending}, 32'd1);
        chk("irq_cause", trap_cause, 32'h80000007);
        step();
        inst_read = 0; trap_start = 1;
        step();
        trap_start = 0;
        chk("irq_vector", trap_vector, 32'h21C);
        chk("irq_mepc", mepc_out, 32'h10);
        expect_csr("irq_mstatus", 12'h300, 32'h80);
        drain();
        trap_finish = 1;
        step();
        trap_finish = 0;
        chk("mret_mepc", mepc_out, 32'h10);
        expect_csr("mret_mstatus", 12'h300, 32'h88);
        drain();
        csr_wr(2'b01, 12'h300, 32'h0);
        inst_read = 1;
        @(negedge clk);
        chk("irq_masked", {31'd0, trap_pending}, 32'd0);
        inst_read = 0;
        csr_wr(2'b01, 12'h300, 32'h8);
        csr_wr(2'b10, 12'h304, 32'h800);
        inst_read = 1;
        @(negedge clk);
        chk("mei_cause", trap_cause, 32'h8000000B);
        inst_read = 0; timer_irq = 0; ext_irq = 0;
        csr_wr(2'b01, 12'h300, 32'h0);

        csr_rd(12'hB02, v0);
        chk("minstret_hold", v0, 32'd5);
        instret = 1;
        repeat (3) step();
        instret = 0;
        csr_rd(12'hB02, v0);
        chk("minstret_inc", v0, 32'd8);
        csr_wr(2'b01, 12'hB80, 32'd5);
        csr_wr(2'b01, 12'hB00, 32'hFFFFFFFF);
        csr_rd(12'hB00, v0);
        chk("mcycle_wr_lo", v0, 32'hFFFFFFFF);
        csr_rd(12'hB80, v0);
        chk("mcycle_carry", v0, 32'd6);
        csr_rd(12'hB00, v0);
        chk("mcycle_wrap", v0, 32'd1);

        // Asynchronous reset while a trap is being committed
        pc = 32'h44; env_call = 1;
        step();
        env_call = 0; trap_start = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_vector", trap_vector, 32'h100);
        chk("arst_mepc", mepc_out, 32'h0);
        step();
        trap_start = 0; rst_n = 1;
        trap_start = 1;
        step();
        trap_start = 0;
        chk("arst_epc_cleared", mepc_out, 32'h0);
        expect_csr("arst_mcause", 12'h342, 32'h0);
        expect_csr("arst_mtvec", 12'h305, 32'h100);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
